// File: rtl/rv32i_mem_arbiter.sv
// ---------------------------------------------------------------------------
// rv32i_mem_arbiter
//
// Shares one instruction/data memory port between instruction fetch (IF) and
// the load/store unit (LSU). At most one memory transaction is outstanding.
// The LSU normally wins arbitration. IF is forced to win after STARVE_LIMIT
// consecutive losses. A branch flush discards an in-flight IF response, but
// the memory side still completes that transaction.
//
// Optional feature (compile-time macro RV32I_MEM_ARB_TIMEOUT_EN):
//   Each transaction gets a wait counter. After MAX_WAIT cycles without a
//   response, the transaction is forced complete and the owner receives an
//   error response.
//
// Ports
//   clk_i, rst_ni            clock (rising edge), async active-low reset
//   flush_i                  branch flush, kills the current/pending IF response
//   if_req_i / if_addr_i     IF read request (held until grant) and address
//   if_gnt_o                 IF grant pulse (combinational)
//   if_rvalid_o/if_err_o     IF response valid / error (combinational)
//   if_rdata_o               IF read data
//   lsu_req_i, lsu_we_i      LSU request, write enable
//   lsu_be_i, lsu_addr_i     LSU byte enables, address
//   lsu_wdata_i              LSU write data
//   lsu_gnt_o                LSU grant pulse (combinational)
//   lsu_rvalid_o/lsu_err_o   LSU response valid / error (combinational)
//   lsu_rdata_o              LSU read data
//   mem_req_o .. mem_wdata_o memory request channel (registered)
//   mem_gnt_i, mem_rvalid_i  memory address accept, response valid
//   mem_rdata_i              memory read data
//   structural_hazard_o      LSU blocked or waiting; the pipeline must stall
// ---------------------------------------------------------------------------
module rv32i_mem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned MAX_WAIT     = 15
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        flush_i,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic        if_gnt_o,
    output logic        if_rvalid_o,
    output logic        if_err_o,
    output logic [31:0] if_rdata_o,
    input  logic        lsu_req_i,
    input  logic        lsu_we_i,
    input  logic [3:0]  lsu_be_i,
    input  logic [31:0] lsu_addr_i,
    input  logic [31:0] lsu_wdata_i,
    output logic        lsu_gnt_o,
    output logic        lsu_rvalid_o,
    output logic        lsu_err_o,
    output logic [31:0] lsu_rdata_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    output logic        structural_hazard_o
);

    localparam int unsigned         STARVE_W   = $clog2(STARVE_LIMIT + 32'd1);
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);
    localparam logic [STARVE_W-1:0] STARVE_ONE = STARVE_W'(1);

    if ((STARVE_LIMIT < 32'd1) || (STARVE_LIMIT > 32'd15)) begin : g_bad_starve_limit
        $error("rv32i_mem_arbiter: STARVE_LIMIT must be in 1..15");
    end
    if ((MAX_WAIT < 32'd2) || (MAX_WAIT > 32'd255)) begin : g_bad_max_wait
        $error("rv32i_mem_arbiter: MAX_WAIT must be in 2..255");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    state_e              state_r;
    state_e              state_s;
    logic                owner_lsu_r;
    logic                drop_r;
    logic                mem_req_r;
    logic                we_r;
    logic [3:0]          be_r;
    logic [31:0]         addr_r;
    logic [31:0]         wdata_r;
    logic [STARVE_W-1:0] starve_r;

    logic if_elig_s;
    logic lsu_elig_s;
    logic if_win_s;
    logic lsu_win_s;
    logic resp_s;
    logic timeout_s;
    logic done_s;
    logic if_vld_s;
    logic lsu_vld_s;
    logic wait_hit_s;

`ifdef RV32I_MEM_ARB_TIMEOUT_EN
    // wait_r counts completed cycles, so the hit fires in the MAX_WAIT-th cycle after the grant.
    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 32'd1);
    logic [7:0] wait_r;

    assign wait_hit_s = (wait_r == WAIT_LAST);

    // Wait counter: restarts on every grant, counts while a transaction is open.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wait_r <= 8'd0;
        end else if (if_win_s || lsu_win_s) begin
            wait_r <= 8'd0;
        end else if (state_r != ST_IDLE) begin
            wait_r <= wait_r + 8'd1;
        end
    end
`else
    assign wait_hit_s = 1'b0;
`endif

    // Arbitration, next state and completion decode.
    always_comb begin
        if_elig_s  = if_req_i && !flush_i;
        lsu_elig_s = lsu_req_i;
        if_win_s   = 1'b0;
        lsu_win_s  = 1'b0;
        resp_s     = 1'b0;
        timeout_s  = 1'b0;
        state_s    = state_r;
        case (state_r)
            ST_IDLE: begin
                if (if_elig_s && lsu_elig_s) begin
                    if (starve_r == STARVE_MAX) begin
                        if_win_s = 1'b1;
                    end else begin
                        lsu_win_s = 1'b1;
                    end
                end else if (if_elig_s) begin
                    if_win_s = 1'b1;
                end else if (lsu_elig_s) begin
                    lsu_win_s = 1'b1;
                end else begin
                    if_win_s  = 1'b0;
                    lsu_win_s = 1'b0;
                end
                if (if_win_s || lsu_win_s) begin
                    state_s = ST_REQ;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                // A response cannot precede address acceptance, so mem_rvalid_i is ignored here.
                if (wait_hit_s) begin
                    timeout_s = 1'b1;
                    state_s   = ST_IDLE;
                end else if (mem_gnt_i) begin
                    state_s = ST_RESP;
                end else begin
                    state_s = ST_REQ;
                end
            end
            ST_RESP: begin
                if (mem_rvalid_i) begin
                    resp_s  = 1'b1;
                    state_s = ST_IDLE;
                end else if (wait_hit_s) begin
                    timeout_s = 1'b1;
                    state_s   = ST_IDLE;
                end else begin
                    state_s = ST_RESP;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    assign done_s    = resp_s || timeout_s;
    // flush_i suppresses the IF response in the same cycle, before drop_r is set.
    assign if_vld_s  = done_s && !owner_lsu_r && !drop_r && !flush_i;
    assign lsu_vld_s = done_s && owner_lsu_r;

    // Combinational outputs are gated by rst_ni so every output reads 0 during reset.
    assign if_gnt_o     = rst_ni && if_win_s;
    assign lsu_gnt_o    = rst_ni && lsu_win_s;
    assign if_rvalid_o  = rst_ni && if_vld_s;
    assign lsu_rvalid_o = rst_ni && lsu_vld_s;
    assign if_rdata_o   = (rst_ni && if_vld_s && resp_s) ? mem_rdata_i : 32'h0000_0000;
    assign lsu_rdata_o  = (rst_ni && lsu_vld_s && resp_s) ? mem_rdata_i : 32'h0000_0000;
`ifdef RV32I_MEM_ARB_TIMEOUT_EN
    assign if_err_o     = rst_ni && if_vld_s && timeout_s;
    assign lsu_err_o    = rst_ni && lsu_vld_s && timeout_s;
`else
    assign if_err_o     = 1'b0;
    assign lsu_err_o    = 1'b0;
`endif
    assign structural_hazard_o = rst_ni &&
        ((lsu_req_i && !lsu_win_s) || ((state_r != ST_IDLE) && owner_lsu_r && !lsu_vld_s));

    assign mem_req_o   = mem_req_r;
    assign mem_we_o    = we_r;
    assign mem_be_o    = be_r;
    assign mem_addr_o  = addr_r;
    assign mem_wdata_o = wdata_r;

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Owner and payload capture at grant; IF fetches are always full-word reads.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            owner_lsu_r <= 1'b0;
            addr_r      <= 32'h0000_0000;
            we_r        <= 1'b0;
            be_r        <= 4'h0;
            wdata_r     <= 32'h0000_0000;
        end else if (if_win_s || lsu_win_s) begin
            owner_lsu_r <= lsu_win_s;
            addr_r      <= lsu_win_s ? lsu_addr_i : if_addr_i;
            we_r        <= lsu_win_s && lsu_we_i;
            be_r        <= lsu_win_s ? lsu_be_i : 4'hF;
            wdata_r     <= lsu_win_s ? lsu_wdata_i : 32'h0000_0000;
        end
    end

    // Memory request: raised by a grant, dropped on address accept or forced completion.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_req_r <= 1'b0;
        end else if (if_win_s || lsu_win_s) begin
            mem_req_r <= 1'b1;
        end else if ((state_r == ST_REQ) && (mem_gnt_i || timeout_s)) begin
            mem_req_r <= 1'b0;
        end
    end

    // Drop flag: a flush during an open IF transaction discards its response.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            drop_r <= 1'b0;
        end else if ((state_r == ST_IDLE) || done_s) begin
            drop_r <= 1'b0;
        end else if (flush_i && !owner_lsu_r) begin
            drop_r <= 1'b1;
        end
    end

    // Starvation counter: counts IF losses to the LSU, cleared whenever IF wins.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            starve_r <= '0;
        end else if (if_win_s) begin
            starve_r <= '0;
        end else if (lsu_win_s && if_elig_s && (starve_r != STARVE_MAX)) begin
            starve_r <= starve_r + STARVE_ONE;
        end
    end

endmodule

// File: tb/tb_rv32i_mem_arbiter.sv
// ---------------------------------------------------------------------------
// Self-checking bench for rv32i_mem_arbiter. A transaction-level reference
// model (busy / accepted / owner / drop, plus integer loss and wait counts)
// predicts every output each cycle. Directed sequences cover the scenarios
// listed for the block, and a randomized phase exercises the rest.
// ---------------------------------------------------------------------------
module tb_rv32i_mem_arbiter;

    localparam int unsigned STARVE_LIMIT = 4;
    localparam int unsigned MAX_WAIT     = 15;
`ifdef RV32I_MEM_ARB_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt, if_rvalid, if_err;
    logic [31:0] if_rdata;
    logic        lsu_req, lsu_we;
    logic [3:0]  lsu_be;
    logic [31:0] lsu_addr, lsu_wdata;
    logic        lsu_gnt, lsu_rvalid, lsu_err;
    logic [31:0] lsu_rdata;
    logic        mem_req, mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_gnt, mem_rvalid;
    logic [31:0] mem_rdata;
    logic        hazard;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    bit          m_busy, m_acc, m_own_lsu, m_drop, m_mreq, m_we;
    int          m_starve, m_wait;
    logic [31:0] m_addr, m_wdata;
    logic [3:0]  m_be;
    // reference model predictions for the current cycle
    bit          e_if_gnt, e_lsu_gnt, e_resp, e_tmo, e_done;
    bit          e_if_rv, e_lsu_rv, e_haz;
    logic [31:0] e_if_rdata, e_lsu_rdata;
    // DUT values sampled in the last cycle
    bit          s_if_gnt, s_lsu_gnt, s_if_rvalid, s_lsu_rvalid, s_lsu_err, s_hazard, s_mem_req;
    logic [31:0] s_lsu_rdata, s_mem_addr;

    rv32i_mem_arbiter #(
        .STARVE_LIMIT (STARVE_LIMIT),
        .MAX_WAIT     (MAX_WAIT)
    ) dut (
        .clk_i               (clk),
        .rst_ni              (rst_n),
        .flush_i             (flush),
        .if_req_i            (if_req),
        .if_addr_i           (if_addr),
        .if_gnt_o            (if_gnt),
        .if_rvalid_o         (if_rvalid),
        .if_err_o            (if_err),
        .if_rdata_o          (if_rdata),
        .lsu_req_i           (lsu_req),
        .lsu_we_i            (lsu_we),
        .lsu_be_i            (lsu_be),
        .lsu_addr_i          (lsu_addr),
        .lsu_wdata_i         (lsu_wdata),
        .lsu_gnt_o           (lsu_gnt),
        .lsu_rvalid_o        (lsu_rvalid),
        .lsu_err_o           (lsu_err),
        .lsu_rdata_o         (lsu_rdata),
        .mem_req_o           (mem_req),
        .mem_we_o            (mem_we),
        .mem_be_o            (mem_be),
        .mem_addr_o          (mem_addr),
        .mem_wdata_o         (mem_wdata),
        .mem_gnt_i           (mem_gnt),
        .mem_rvalid_i        (mem_rvalid),
        .mem_rdata_i         (mem_rdata),
        .structural_hazard_o (hazard)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, obs, exp);
        end
    endtask

    function automatic void model_reset();
        m_busy = 0; m_acc = 0; m_own_lsu = 0; m_drop = 0; m_mreq = 0; m_we = 0;
        m_starve = 0; m_wait = 0; m_addr = '0; m_wdata = '0; m_be = '0;
    endfunction

    // Predict combinational outputs from the transaction record and current inputs.
    function automatic void model_comb();
        bit if_e, lsu_e;
        if_e = if_req && !flush;
        lsu_e = lsu_req;
        e_if_gnt = 0;
        e_lsu_gnt = 0;
        if (!m_busy) begin
            if (if_e && lsu_e) begin
                if (m_starve == STARVE_LIMIT) e_if_gnt = 1; else e_lsu_gnt = 1;
            end else begin
                e_if_gnt = if_e;
                e_lsu_gnt = lsu_e;
            end
        end
        e_resp = m_busy && m_acc && mem_rvalid;
        e_tmo = TMO_EN && m_busy && !e_resp && (m_wait + 1 >= MAX_WAIT);
        e_done = e_resp || e_tmo;
        e_if_rv = e_done && !m_own_lsu && !m_drop && !flush;
        e_lsu_rv = e_done && m_own_lsu;
        e_if_rdata = (e_if_rv && e_resp) ? mem_rdata : 32'h0;
        e_lsu_rdata = (e_lsu_rv && e_resp) ? mem_rdata : 32'h0;
        e_haz = (lsu_req && !e_lsu_gnt) || (m_busy && m_own_lsu && !e_lsu_rv);
    endfunction

    // Advance the transaction record at the clock edge.
    function automatic void model_seq();
        if (!m_busy) begin
            if (e_if_gnt || e_lsu_gnt) begin
                m_busy = 1; m_acc = 0; m_own_lsu = e_lsu_gnt; m_mreq = 1; m_wait = 0; m_drop = 0;
                m_addr = e_lsu_gnt ? lsu_addr : if_addr;
                m_we = e_lsu_gnt ? lsu_we : 1'b0;
                m_be = e_lsu_gnt ? lsu_be : 4'hF;
                m_wdata = e_lsu_gnt ? lsu_wdata : 32'h0;
                if (e_if_gnt) m_starve = 0;
                else if (if_req && !flush) m_starve++;
            end
        end else if (e_done) begin
            m_busy = 0; m_acc = 0; m_mreq = 0; m_drop = 0;
        end else begin
            if (flush && !m_own_lsu) m_drop = 1;
            if (!m_acc && mem_gnt) begin
                m_acc = 1;
                m_mreq = 0;
            end
            m_wait++;
        end
    endfunction

    // One clock cycle: inputs already driven at the falling edge.
    task automatic cycle();
        #1;
        model_comb();
        check_val("if_gnt", 32'(if_gnt), 32'(e_if_gnt));
        check_val("lsu_gnt", 32'(lsu_gnt), 32'(e_lsu_gnt));
        check_val("if_rvalid", 32'(if_rvalid), 32'(e_if_rv));
        check_val("if_err", 32'(if_err), 32'(e_if_rv && e_tmo));
        check_val("if_rdata", if_rdata, e_if_rdata);
        check_val("lsu_rvalid", 32'(lsu_rvalid), 32'(e_lsu_rv));
        check_val("lsu_err", 32'(lsu_err), 32'(e_lsu_rv && e_tmo));
        check_val("lsu_rdata", lsu_rdata, e_lsu_rdata);
        check_val("hazard", 32'(hazard), 32'(e_haz));
        check_val("mem_req", 32'(mem_req), 32'(m_mreq));
        check_val("mem_we", 32'(mem_we), 32'(m_we));
        check_val("mem_be", 32'(mem_be), 32'(m_be));
        check_val("mem_addr", mem_addr, m_addr);
        check_val("mem_wdata", mem_wdata, m_wdata);
        s_if_gnt = if_gnt; s_lsu_gnt = lsu_gnt; s_if_rvalid = if_rvalid;
        s_lsu_rvalid = lsu_rvalid; s_lsu_err = lsu_err; s_lsu_rdata = lsu_rdata;
        s_hazard = hazard; s_mem_req = mem_req; s_mem_addr = mem_addr;
        @(posedge clk);
        model_seq();
        @(negedge clk);
    endtask

    task automatic set_idle();
        flush = 0; if_req = 0; if_addr = '0; lsu_req = 0; lsu_we = 0; lsu_be = '0;
        lsu_addr = '0; lsu_wdata = '0; mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0;
    endtask

    task automatic drain();
        set_idle();
        mem_gnt = 1;
        mem_rvalid = 1;
        for (int i = 0; i < 8 && m_busy; i++) cycle();
        set_idle();
        cycle();
    endtask

    task automatic check_all_zero(input string pre);
        check_val({pre, "_if_gnt"}, 32'(if_gnt), 32'h0);
        check_val({pre, "_lsu_gnt"}, 32'(lsu_gnt), 32'h0);
        check_val({pre, "_if_rvalid"}, 32'(if_rvalid), 32'h0);
        check_val({pre, "_if_err"}, 32'(if_err), 32'h0);
        check_val({pre, "_if_rdata"}, if_rdata, 32'h0);
        check_val({pre, "_lsu_rvalid"}, 32'(lsu_rvalid), 32'h0);
        check_val({pre, "_lsu_err"}, 32'(lsu_err), 32'h0);
        check_val({pre, "_lsu_rdata"}, lsu_rdata, 32'h0);
        check_val({pre, "_hazard"}, 32'(hazard), 32'h0);
        check_val({pre, "_mem_req"}, 32'(mem_req), 32'h0);
        check_val({pre, "_mem_we"}, 32'(mem_we), 32'h0);
        check_val({pre, "_mem_be"}, 32'(mem_be), 32'h0);
        check_val({pre, "_mem_addr"}, mem_addr, 32'h0);
        check_val({pre, "_mem_wdata"}, mem_wdata, 32'h0);
    endtask

    initial begin : stim
        bit grants[$];
        bit exp_order[10];
        bit if_pend, lsu_pend;
        int got;

        set_idle();
        rst_n = 0;
        model_reset();
        if_req = 1; lsu_req = 1; mem_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        @(negedge clk);
        #1;
        check_all_zero("in_reset");
        set_idle();
        rst_n = 1;
        cycle();

        // LSU load against zero-wait memory
        lsu_req = 1; lsu_addr = 32'h0000_0100;
        cycle();
        check_val("load_gnt_N", 32'(s_lsu_gnt), 32'h1);
        set_idle(); mem_gnt = 1;
        cycle();
        check_val("load_mem_req_N1", 32'(s_mem_req), 32'h1);
        check_val("load_mem_addr_N1", s_mem_addr, 32'h0000_0100);
        check_val("load_hazard_N1", 32'(s_hazard), 32'h1);
        set_idle(); mem_rvalid = 1; mem_rdata = 32'hDEAD_BEEF;
        cycle();
        check_val("load_rvalid_N2", 32'(s_lsu_rvalid), 32'h1);
        check_val("load_rdata_N2", s_lsu_rdata, 32'hDEAD_BEEF);
        check_val("load_hazard_N2", 32'(s_hazard), 32'h0);
        set_idle();
        cycle();

        // flush while idle: request is not eligible
        if_req = 1; flush = 1; if_addr = 32'h0000_0040;
        cycle();
        check_val("idle_flush_if_gnt", 32'(s_if_gnt), 32'h0);
        check_val("idle_flush_lsu_gnt", 32'(s_lsu_gnt), 32'h0);
        set_idle();
        cycle();
        check_val("idle_flush_mem_req", 32'(s_mem_req), 32'h0);

        // flush during an IF transaction, LSU waiting behind it
        if_req = 1; if_addr = 32'h0000_0080;
        cycle();
        check_val("flush_if_gnt", 32'(s_if_gnt), 32'h1);
        set_idle(); lsu_req = 1; lsu_addr = 32'h0000_0180; mem_gnt = 1;
        cycle();
        mem_gnt = 0; flush = 1;
        cycle();
        flush = 0; mem_rvalid = 1; mem_rdata = 32'h1234_5678;
        cycle();
        check_val("flush_if_rvalid", 32'(s_if_rvalid), 32'h0);
        check_val("flush_no_gnt_in_resp", 32'(s_lsu_gnt), 32'h0);
        mem_rvalid = 0;
        cycle();
        check_val("flush_lsu_gnt_next", 32'(s_lsu_gnt), 32'h1);
        drain();

        // starvation: both requesting, zero-wait memory
        exp_order = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
        if_req = 1; if_addr = 32'h0000_1000;
        lsu_req = 1; lsu_addr = 32'h0000_2000; lsu_be = 4'hF;
        mem_gnt = 1; mem_rvalid = 1;
        for (int i = 0; i < 30; i++) begin
            cycle();
            if (s_lsu_gnt) grants.push_back(1'b1);
            if (s_if_gnt) grants.push_back(1'b0);
        end
        check_val("starve_grant_count", 32'(grants.size()), 32'd10);
        for (int i = 0; i < 10; i++) begin
            if (i < grants.size()) check_val($sformatf("starve_grant_%0d", i), 32'(grants[i]), 32'(exp_order[i]));
        end
        drain();

        // randomized traffic checked against the model
        if_pend = 0; lsu_pend = 0;
        for (int i = 0; i < 3000; i++) begin
            if (!if_pend && ($urandom_range(0, 99) < 40)) begin
                if_pend = 1;
                if_addr = $urandom;
            end
            if (!lsu_pend && ($urandom_range(0, 99) < 40)) begin
                lsu_pend = 1;
                lsu_addr = $urandom;
                lsu_we = 1'($urandom_range(0, 1));
                lsu_be = 4'($urandom_range(0, 15));
                lsu_wdata = $urandom;
            end
            if_req = if_pend;
            lsu_req = lsu_pend;
            flush = ($urandom_range(0, 9) == 0);
            mem_gnt = 1'($urandom_range(0, 1));
            mem_rvalid = ($urandom_range(0, 99) < 45);
            mem_rdata = $urandom;
            cycle();
            if (e_if_gnt) if_pend = 0;
            if (e_lsu_gnt) lsu_pend = 0;
        end
        drain();

`ifdef RV32I_MEM_ARB_TIMEOUT_EN
        // store that memory never accepts
        lsu_req = 1; lsu_we = 1; lsu_be = 4'h3; lsu_addr = 32'h0000_0400; lsu_wdata = 32'hCAFE_0001;
        cycle();
        check_val("tmo_gnt", 32'(s_lsu_gnt), 32'h1);
        set_idle();
        got = 0;
        for (int k = 1; k <= 40; k++) begin
            cycle();
            if (s_lsu_rvalid) begin
                got = k;
                break;
            end
        end
        check_val("tmo_cycles_after_gnt", 32'(got), 32'(MAX_WAIT));
        check_val("tmo_err", 32'(s_lsu_err), 32'h1);
        mem_rvalid = 1; mem_rdata = 32'h5555_AAAA;
        cycle();
        check_val("tmo_late_rvalid", 32'(s_lsu_rvalid), 32'h0);
        check_val("tmo_mem_req_low", 32'(s_mem_req), 32'h0);
        drain();
`endif

        // asynchronous reset while in RESP
        lsu_req = 1; lsu_addr = 32'h0000_0200;
        cycle();
        set_idle(); mem_gnt = 1;
        cycle();
        set_idle(); if_req = 1; lsu_req = 1; lsu_addr = 32'h0000_0300;
        #2;
        rst_n = 0;
        #1;
        check_all_zero("async_rst");
        @(posedge clk);
        #1;
        check_val("rst_hold_mem_req", 32'(mem_req), 32'h0);
        @(negedge clk);
        rst_n = 1;
        model_reset();
        if_req = 0;
        cycle();
        check_val("post_rst_gnt", 32'(s_lsu_gnt), 32'h1);
        set_idle(); mem_gnt = 1;
        cycle();
        check_val("post_rst_mem_addr", s_mem_addr, 32'h0000_0300);
        set_idle(); mem_rvalid = 1; mem_rdata = 32'h0BAD_F00D;
        cycle();
        check_val("post_rst_rdata", s_lsu_rdata, 32'h0BAD_F00D);
        set_idle();
        cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
